// File: rtl/reaction_arbiter_pkg.sv
// reaction_arbiter_pkg
//   Shared encodings for the reaction-game arbiter: FSM state type and the
//   2-bit result codes that drive the result LEDs.
package reaction_arbiter_pkg;

   typedef enum logic [1:0] {
      WAIT_CD = 2'd0,
      RACE    = 2'd1,
      DONE    = 2'd2
   } arb_state_t;

   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_P1   = 2'b01;
   localparam logic [1:0] RES_P2   = 2'b10;
   localparam logic [1:0] RES_TIE  = 2'b11;

   // Result for a decision where p1/p2 are the press events seen that cycle.
   // In a false start the opponent of the single presser wins; a double
   // false start has no winner.
   function automatic logic [1:0] decide(input logic p1, input logic p2,
                                         input logic false_start);
      logic [1:0] res;
      res = RES_NONE;
      if (p1 && p2)
         res = false_start ? RES_NONE : RES_TIE;
      else if (p1)
         res = false_start ? RES_P2 : RES_P1;
      else if (p2)
         res = false_start ? RES_P1 : RES_P2;
      return res;
   endfunction

endpackage

// File: rtl/reaction_arbiter_button_conditioner.sv
// reaction_arbiter_button_conditioner
//   Synchronizer + debouncer + rising-edge pulse for one raw player button.
//   Pad-to-press_evt latency is SYNC_STAGES+DEBOUNCE_COUNT cycles.
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   btn_in     raw asynchronous button, active-high
//   press_evt  1-cycle pulse on a debounced 0->1 transition
module reaction_arbiter_button_conditioner #(
   parameter int SYNC_STAGES    = 2,
   parameter int DEBOUNCE_COUNT = 12000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic press_evt
);

   localparam int CW = $clog2(DEBOUNCE_COUNT);
   localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_COUNT - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic                   stable_q;
   logic [CW-1:0]          cnt_q;

   assign synced = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q    <= '0;
         stable_q  <= 1'b0;
         cnt_q     <= '0;
         press_evt <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_in};
         press_evt <= 1'b0;
         // Any return to the stable level restarts the stability window.
         if (synced == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_TC) begin
            stable_q  <= synced;
            cnt_q     <= '0;
            press_evt <= synced;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/reaction_arbiter.sv
// reaction_arbiter
//   Decides the winner of the reaction game from the countdown done level and
//   the two player buttons. The result is latched until reset.
//   Optional feature macro: ARB_TIMEOUT_EN (RACE gives up with no winner after
//   TIMEOUT_COUNT cycles; otherwise RACE waits forever and timeout_out is 0).
// Ports:
//   clk              system clock
//   reset            synchronous, active-low reset
//   cd_done_in       countdown finished (level)
//   btn_p1_in        player 1 raw button, active-high
//   btn_p2_in        player 2 raw button, active-high
//   done_out         game decided, result_out valid
//   result_out       00 none, 01 P1, 10 P2, 11 tie
//   false_start_out  decision caused by an early press
//   timeout_out      decision caused by a timeout
//
// state   | meaning
// WAIT_CD | countdown running; any press is a false start
// RACE    | countdown over; first press wins
// DONE    | result latched until reset
module reaction_arbiter
   import reaction_arbiter_pkg::*;
#(
   parameter int CLOCK_FREQ     = 12000000,
   parameter int SYNC_STAGES    = 2,
   parameter int DEBOUNCE_COUNT = CLOCK_FREQ / 1000,
   parameter int TIMEOUT_COUNT  = CLOCK_FREQ * 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cd_done_in,
   input  logic       btn_p1_in,
   input  logic       btn_p2_in,
   output logic       done_out,
   output logic [1:0] result_out,
   output logic       false_start_out,
   output logic       timeout_out
);

   if (CLOCK_FREQ < 1 || SYNC_STAGES < 2 || DEBOUNCE_COUNT < 2 || TIMEOUT_COUNT < 2) begin : g_bad_param
      $error("reaction_arbiter: illegal parameter value");
   end

   logic p1_evt, p2_evt;

   reaction_arbiter_button_conditioner #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
   ) u_cond_p1 (
      .clk      (clk),
      .reset    (reset),
      .btn_in   (btn_p1_in),
      .press_evt(p1_evt)
   );

   reaction_arbiter_button_conditioner #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
   ) u_cond_p2 (
      .clk      (clk),
      .reset    (reset),
      .btn_in   (btn_p2_in),
      .press_evt(p2_evt)
   );

   arb_state_t state_q, state_d;
   logic [1:0] result_q, result_d;
   logic       done_q, done_d;
   logic       fs_q, fs_d;
   logic       any_evt;

   assign any_evt = p1_evt | p2_evt;

`ifdef ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_COUNT);
   localparam logic [TW-1:0] TMO_TC = TW'(TIMEOUT_COUNT - 1);

   logic [TW-1:0] tmo_cnt_q;
   logic          to_q, to_d;

   // Held at zero outside RACE, so it is cleared on RACE entry.
   always_ff @(posedge clk) begin
      if (!reset || state_q != RACE)
         tmo_cnt_q <= '0;
      else
         tmo_cnt_q <= tmo_cnt_q + TW'(1);
   end

   assign timeout_out = to_q;
`else
   assign timeout_out = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      done_d   = done_q;
      fs_d     = fs_q;
`ifdef ARB_TIMEOUT_EN
      to_d     = to_q;
`endif
      case (state_q)
         WAIT_CD: begin
            // A press on the cycle the countdown ends still counts as early.
            if (any_evt) begin
               state_d  = DONE;
               done_d   = 1'b1;
               fs_d     = 1'b1;
               result_d = decide(p1_evt, p2_evt, 1'b1);
            end else if (cd_done_in) begin
               state_d = RACE;
            end
         end
         RACE: begin
            if (any_evt) begin
               state_d  = DONE;
               done_d   = 1'b1;
               result_d = decide(p1_evt, p2_evt, 1'b0);
            end
`ifdef ARB_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_TC) begin
               state_d  = DONE;
               done_d   = 1'b1;
               to_d     = 1'b1;
               result_d = RES_NONE;
            end
`endif
         end
         DONE:    state_d = DONE;
         default: state_d = WAIT_CD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= WAIT_CD;
         result_q <= RES_NONE;
         done_q   <= 1'b0;
         fs_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         to_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         done_q   <= done_d;
         fs_q     <= fs_d;
`ifdef ARB_TIMEOUT_EN
         to_q     <= to_d;
`endif
      end
   end

   assign done_out        = done_q;
   assign result_out      = result_q;
   assign false_start_out = fs_q;

endmodule

// File: tb/tb_reaction_arbiter.sv
module tb_reaction_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cd_done_in = 1'b0;
   logic       btn_p1_in = 1'b0;
   logic       btn_p2_in = 1'b0;
   logic       done_out;
   logic [1:0] result_out;
   logic       false_start_out;
   logic       timeout_out;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string      tag;
      logic [1:0] res;
      logic       fs;
      logic       to;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   reaction_arbiter #(
      .CLOCK_FREQ    (12000000),
      .SYNC_STAGES   (2),
      .DEBOUNCE_COUNT(8),
      .TIMEOUT_COUNT (50)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .cd_done_in     (cd_done_in),
      .btn_p1_in      (btn_p1_in),
      .btn_p2_in      (btn_p2_in),
      .done_out       (done_out),
      .result_out     (result_out),
      .false_start_out(false_start_out),
      .timeout_out    (timeout_out)
   );

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cd_done_in = 1'b0;
      btn_p1_in = 1'b0;
      btn_p2_in = 1'b0;
      step(2);
      reset = 1'b1;
   endtask

   task automatic push_exp(input string tag, input logic [1:0] res, input logic fs, input logic to);
      exp_t e;
      e.tag = tag;
      e.res = res;
      e.fs  = fs;
      e.to  = to;
      sb_q.push_back(e);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_done"},   32'(done_out), 32'd0);
      chk({tag, "_result"}, 32'(result_out), 32'd0);
      chk({tag, "_fs"},     32'(false_start_out), 32'd0);
      chk({tag, "_to"},     32'(timeout_out), 32'd0);
   endtask

   // Wait (bounded) for done_out, then pop the oldest expectation and compare.
   task automatic wait_decision(input int max_cyc, output int lat);
      exp_t e;
      lat = 0;
      while (done_out !== 1'b1 && lat < max_cyc) begin
         step(1);
         lat++;
      end
      chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({e.tag, "_done"},   32'(done_out), 32'd1);
         chk({e.tag, "_result"}, 32'(result_out), 32'(e.res));
         chk({e.tag, "_fs"},     32'(false_start_out), 32'(e.fs));
         chk({e.tag, "_to"},     32'(timeout_out), 32'(e.to));
      end
   endtask

   initial begin
      int lat;
      bit seen;

      // 1: reset state and idle countdown
      reset = 1'b0;
      step(2);
      chk_idle("reset");
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step(1);
         seen |= done_out | false_start_out | timeout_out | (|result_out);
      end
      chk("idle_any_output", 32'(seen), 32'd0);
      chk_idle("idle");

      // 2: race, P1 wins, pad-to-done latency 11
      do_reset();
      cd_done_in = 1'b1;
      step(2);
      btn_p1_in = 1'b1;
      push_exp("race_p1", 2'b01, 1'b0, 1'b0);
      wait_decision(40, lat);
      chk("race_p1_latency", 32'(lat), 32'd11);
      step(9);
      btn_p1_in = 1'b0;
      btn_p2_in = 1'b1;
      step(20);
      btn_p2_in = 1'b0;
      step(2);
      chk("race_p1_sticky_result", 32'(result_out), 32'd1);

      // 3: P2 false start, later P1 press ignored, then reset clears result
      do_reset();
      btn_p2_in = 1'b1;
      push_exp("fs_p2", 2'b01, 1'b1, 1'b0);
      wait_decision(40, lat);
      chk("fs_p2_latency", 32'(lat), 32'd11);
      step(10);
      btn_p2_in = 1'b0;
      cd_done_in = 1'b1;
      step(2);
      btn_p1_in = 1'b1;
      step(20);
      btn_p1_in = 1'b0;
      step(5);
      chk("fs_p2_sticky_done", 32'(done_out), 32'd1);
      chk("fs_p2_sticky_result", 32'(result_out), 32'd1);
      chk("fs_p2_sticky_fs", 32'(false_start_out), 32'd1);
      reset = 1'b0;
      step(1);
      chk_idle("reset_after_done");

      // 4a: tie in RACE
      do_reset();
      cd_done_in = 1'b1;
      step(2);
      btn_p1_in = 1'b1;
      btn_p2_in = 1'b1;
      push_exp("race_tie", 2'b11, 1'b0, 1'b0);
      wait_decision(40, lat);
      btn_p1_in = 1'b0;
      btn_p2_in = 1'b0;

      // 4b: double false start
      do_reset();
      btn_p1_in = 1'b1;
      btn_p2_in = 1'b1;
      push_exp("fs_both", 2'b00, 1'b1, 1'b0);
      wait_decision(40, lat);
      btn_p1_in = 1'b0;
      btn_p2_in = 1'b0;

      // Press event on the very cycle the countdown ends: still a false start
      do_reset();
      btn_p1_in = 1'b1;
      step(10);
      chk("edge_not_yet_done", 32'(done_out), 32'd0);
      cd_done_in = 1'b1;
      push_exp("fs_cd_same_cycle", 2'b10, 1'b1, 1'b0);
      wait_decision(5, lat);
      chk("fs_cd_same_cycle_latency", 32'(lat), 32'd1);
      btn_p1_in = 1'b0;

      // 5: bounce in RACE never produces a press, then reset mid-RACE
      do_reset();
      cd_done_in = 1'b1;
      step(2);
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         btn_p1_in = 1'b1;
         for (int i = 0; i < 5; i++) begin step(1); seen |= done_out; end
         btn_p1_in = 1'b0;
         for (int i = 0; i < 5; i++) begin step(1); seen |= done_out; end
      end
      for (int i = 0; i < 30; i++) begin step(1); seen |= done_out; end
      chk("bounce_no_decision", 32'(seen), 32'd0);
      reset = 1'b0;
      cd_done_in = 1'b0;
      step(1);
      chk_idle("reset_mid_race");
      reset = 1'b1;
      btn_p1_in = 1'b1;
      push_exp("after_mid_reset_fs", 2'b10, 1'b1, 1'b0);
      wait_decision(40, lat);
      btn_p1_in = 1'b0;

      // 6: no press in RACE
      do_reset();
      cd_done_in = 1'b1;
`ifdef ARB_TIMEOUT_EN
      push_exp("timeout", 2'b00, 1'b0, 1'b1);
      wait_decision(200, lat);
      // RACE entered on the first edge after cd_done_in, timeout 50 edges later.
      chk("timeout_latency", 32'(lat), 32'd51);
`else
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         step(1);
         seen |= done_out | timeout_out;
      end
      chk("no_timeout_done", 32'(seen), 32'd0);
      chk_idle("no_timeout_idle");
`endif

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end

endmodule
